div_issue_ctrl: RTL and testbench
=================================

# div_issue_ctrl

Requester-side controller for the multi-cycle divider. It sits in the EX stage between the pipeline and the divider's valid/ready/complete port. It latches DIV/DIVU operands, issues the request, stalls EX until the result returns, and commits quotient/remainder into the architectural LO/HI registers. It also absorbs pipeline flushes while a divide is in flight, and serialises MTHI/MTLO against outstanding divides.

## Interface
- No parameters; datapath fixed at 32 bits.
- div_clk  in  1  clock.
- div_reset  in  1  synchronous reset, active-high.
- ex_valid  in  1  EX holds a valid instruction.
- ex_div  in  1  the EX instruction is DIV/DIVU.
- ex_div_signed  in  1  1 = DIV, 0 = DIVU.
- ex_rs  in  32  dividend.
- ex_rt  in  32  divisor.
- ex_mthi / ex_mtlo  in  1  the EX instruction is MTHI/MTLO.
- ex_mt_data  in  32  MTHI/MTLO source.
- ex_flush  in  1  cancel the EX instruction (exception/ERET).
- ex_stall  out  1  hold EX; combinational.
- hi, lo  out  32  architectural HI/LO.
- div_valid  out  1  request to the divider; registered.
- div_dividend, div_divisor  out  32  request operands; registered.
- div_signed  out  1  registered signed flag.
- div_ready  in  1  the divider can accept a request.
- div_complete  in  1  one-cycle pulse; div_quo/div_rem are valid in that cycle.
- div_quo, div_rem  in  32  divider results.

## Operation
- Register reset values: state=IDLE, hi=lo=0, div_valid=0, operand registers=0, result registers=0.
- The divider instance is reset by the same div_reset event. Its active-low reset is the inverse of div_reset.
- A new divide is seen when ex_valid & ex_div & ~ex_flush.
- IDLE
  - New divide: latch ex_rs, ex_rt and ex_div_signed into the request registers, set div_valid, and go to REQ.
  - MTHI/MTLO with ex_valid & ~ex_flush: write ex_mt_data into hi/lo at the edge.
- REQ
  - div_valid is held high and the operands are held stable.
  - Handshake fires when div_valid & div_ready. On that edge div_valid clears and the state goes to WAIT, or to DRAIN if ex_flush is high in the same cycle.
  - ex_flush without a handshake: clear div_valid and return to IDLE.
- WAIT
  - On div_complete: capture div_quo/div_rem into result registers and go to DONE.
  - ex_flush without div_complete: go to DRAIN.
  - ex_flush together with div_complete: go to DRAIN; the result is discarded.
- DONE (exactly 1 cycle)
  - ex_stall=0, so the divide leaves EX.
  - If ~ex_flush: lo<=quotient, hi<=remainder.
  - Next state is IDLE. A divide is never re-issued from DONE.
- DRAIN
  - Wait for div_complete and discard the result; hi/lo are unchanged.
  - div_valid is never raised while in DRAIN.
  - On div_complete go to IDLE.
- ex_stall is high when any of these hold:
  - IDLE with a new divide;
  - REQ or WAIT, unless ex_flush is high;
  - DRAIN with ex_valid & (ex_div | ex_mthi | ex_mtlo).
- Operands pass to the divider unmodified. Sign handling belongs to the divider.

## Timing
- Divide seen in IDLE at cycle T:
  - div_valid is high from T+1. With div_ready high, the handshake fires at T+1.
  - div_complete arrives at cycle C. DONE is at C+1. hi/lo are visible at C+2.
- EX stall runs from T through C inclusive; the instruction advances at the DONE edge.
- div_valid is high for at least one cycle per request and drops the cycle after acceptance.
- The next request cannot issue before the cycle after DONE.
- div_reset mid-operation: the controller returns to IDLE next edge, hi/lo clear, and no residual div_valid is driven.

## Configuration
- DIV_ZERO_BYPASS_EN defined:
  - A new divide with ex_rt==0 skips the divider: no div_valid, IDLE goes straight to DONE.
  - In DONE: lo<=32'hFFFFFFFF, hi<=ex_rs, unless flushed.
  - Total stall is 1 cycle.
- Undefined: a zero divisor is issued like any other divide, and hi/lo take whatever the divider returns.

## Test plan
- Reset: assert div_reset for 2 cycles -> hi=lo=0, div_valid=0, ex_stall=0.
- DIVU 100/7:
  - div_valid pulses with div_dividend=100, div_divisor=7, div_signed=0.
  - ex_stall stays high through div_complete.
  - Then lo=14, hi=2.
- DIV 0xFFFFFFF9 / 2 (signed) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Flush 5 cycles into WAIT:
  - The state enters DRAIN and a following DIV stalls until the old div_complete.
  - Exactly one new div_valid is seen afterwards.
  - hi/lo keep their prior values until the new result.
- DIVU 9/4 followed immediately by MTHI 0x55 -> lo=2, then hi=0x55; MTHI is never applied before DONE.
- DIV_ZERO_BYPASS_EN: DIVU 0x1234/0 -> no div_valid, ex_stall for 1 cycle, lo=0xFFFFFFFF, hi=0x1234.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// EX-stage requester for the multi-cycle divider: issues DIV/DIVU, stalls EX, commits LO/HI.
// Optional macro DIV_ZERO_BYPASS_EN resolves zero-divisor divides locally without using the divider.
module div_issue_ctrl (
  input  logic        div_clk,
  input  logic        div_reset,
  input  logic        ex_valid,
  input  logic        ex_div,
  input  logic        ex_div_signed,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        ex_mthi,
  input  logic        ex_mtlo,
  input  logic [31:0] ex_mt_data,
  input  logic        ex_flush,
  output logic        ex_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_valid,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_signed,
  input  logic        div_ready,
  input  logic        div_complete,
  input  logic [31:0] div_quo,
  input  logic [31:0] div_rem
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  state_e      state_r;
  state_e      state_nxt_s;
  logic        new_div_s;
  logic        mt_ok_s;
  logic        hs_s;
  logic        zero_byp_s;
  logic        issue_s;
  logic        byp_load_s;
  logic        cap_res_s;
  logic        commit_s;
  logic        clr_valid_s;
  logic        mt_hi_s;
  logic        mt_lo_s;
  logic [31:0] quo_r;
  logic [31:0] rem_r;

  assign new_div_s = ex_valid & ex_div & ~ex_flush;
  assign mt_ok_s   = ex_valid & ~ex_flush;
  assign hs_s      = div_valid & div_ready;

`ifdef DIV_ZERO_BYPASS_EN
  assign zero_byp_s = (ex_rt == 32'd0);
`else
  assign zero_byp_s = 1'b0;
`endif

  // Next-state, EX stall and datapath strobes
  always_comb begin
    state_nxt_s = state_r;
    ex_stall    = 1'b0;
    issue_s     = 1'b0;
    byp_load_s  = 1'b0;
    cap_res_s   = 1'b0;
    commit_s    = 1'b0;
    clr_valid_s = 1'b0;
    mt_hi_s     = 1'b0;
    mt_lo_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (new_div_s) begin
          ex_stall = 1'b1;
          if (zero_byp_s) begin
            byp_load_s  = 1'b1;
            state_nxt_s = ST_DONE;
          end else begin
            issue_s     = 1'b1;
            state_nxt_s = ST_REQ;
          end
        end else begin
          mt_hi_s     = mt_ok_s & ex_mthi;
          mt_lo_s     = mt_ok_s & ex_mtlo;
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        ex_stall = ~ex_flush;
        if (hs_s) begin
          clr_valid_s = 1'b1;
          state_nxt_s = ex_flush ? ST_DRAIN : ST_WAIT;
        end else if (ex_flush) begin
          clr_valid_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        ex_stall = ~ex_flush;
        // A flush wins over a coinciding completion; that result is dropped
        if (ex_flush) begin
          state_nxt_s = ST_DRAIN;
        end else if (div_complete) begin
          cap_res_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (ex_flush) begin
          commit_s = 1'b0;
        end else begin
          commit_s = 1'b1;
        end
        state_nxt_s = ST_IDLE;
      end
      ST_DRAIN: begin
        ex_stall = ex_valid & (ex_div | ex_mthi | ex_mtlo);
        if (div_complete) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ex_stall    = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge div_clk) begin
    if (div_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request, result and architectural HI/LO registers
  always_ff @(posedge div_clk) begin
    if (div_reset) begin
      div_valid    <= 1'b0;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
      div_signed   <= 1'b0;
      quo_r        <= 32'd0;
      rem_r        <= 32'd0;
      hi           <= 32'd0;
      lo           <= 32'd0;
    end else begin
      if (issue_s) begin
        div_valid    <= 1'b1;
        div_dividend <= ex_rs;
        div_divisor  <= ex_rt;
        div_signed   <= ex_div_signed;
      end else if (clr_valid_s) begin
        div_valid <= 1'b0;
      end
      if (cap_res_s) begin
        quo_r <= div_quo;
        rem_r <= div_rem;
      end else if (byp_load_s) begin
        quo_r <= 32'hFFFF_FFFF;
        rem_r <= ex_rs;
      end
      if (commit_s) begin
        lo <= quo_r;
        hi <= rem_r;
      end else begin
        if (mt_hi_s) begin
          hi <= ex_mt_data;
        end
        if (mt_lo_s) begin
          lo <= ex_mt_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl: expected requests and HI/LO updates are queued by the
// stimulus and popped by a monitor; a behavioural divider answers requests after `lat` cycles.
module tb_div_issue_ctrl;

  logic        div_clk = 1'b0;
  logic        div_reset;
  logic        ex_valid, ex_div, ex_div_signed, ex_mthi, ex_mtlo, ex_flush;
  logic [31:0] ex_rs, ex_rt, ex_mt_data;
  logic        ex_stall;
  logic [31:0] hi, lo;
  logic        div_valid, div_signed;
  logic [31:0] div_dividend, div_divisor;
  logic        div_ready, div_complete;
  logic [31:0] div_quo, div_rem;

  always #5 div_clk = ~div_clk;

  div_issue_ctrl dut (
    .div_clk(div_clk), .div_reset(div_reset),
    .ex_valid(ex_valid), .ex_div(ex_div), .ex_div_signed(ex_div_signed),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mthi(ex_mthi), .ex_mtlo(ex_mtlo),
    .ex_mt_data(ex_mt_data), .ex_flush(ex_flush), .ex_stall(ex_stall),
    .hi(hi), .lo(lo), .div_valid(div_valid), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_signed(div_signed), .div_ready(div_ready),
    .div_complete(div_complete), .div_quo(div_quo), .div_rem(div_rem)
  );

  typedef struct packed {logic [31:0] a; logic [31:0] b; logic s;} req_t;
  typedef struct packed {logic [31:0] hi; logic [31:0] lo;} hilo_t;

  req_t  req_q[$];
  hilo_t hilo_q[$];
  int    pass_cnt = 0;
  int    total_cnt = 0;
  int    hs_cnt = 0;
  int    lat = 4;
  bit    mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: pops expectations on each request handshake and on each HI/LO change
  logic [31:0] prev_hi = 32'd0;
  logic [31:0] prev_lo = 32'd0;
  initial begin
    req_t  r;
    hilo_t h;
    forever begin
      @(negedge div_clk);
      if (mon_en && div_valid && div_ready) begin
        hs_cnt++;
        if (req_q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
        else begin
          r = req_q.pop_front();
          check("req_dividend", div_dividend, r.a);
          check("req_divisor", div_divisor, r.b);
          check("req_signed", 32'(div_signed), 32'(r.s));
        end
      end
      if (mon_en && (hi !== prev_hi || lo !== prev_lo)) begin
        if (hilo_q.size() == 0) check("unexpected_hilo_change", 32'd1, 32'd0);
        else begin
          h = hilo_q.pop_front();
          check("hilo_hi", hi, h.hi);
          check("hilo_lo", lo, h.lo);
        end
      end
      prev_hi = hi;
      prev_lo = lo;
    end
  end

  // Behavioural divider: single outstanding request, completes `lat` cycles after acceptance
  logic [31:0] rsp_a, rsp_b;
  logic        rsp_s;
  bit          rsp_busy = 1'b0;
  bit          rsp_hs;
  int          rsp_cnt = 0;
  initial begin
    div_ready = 1'b1; div_complete = 1'b0; div_quo = 32'd0; div_rem = 32'd0;
    forever begin
      @(negedge div_clk);
      rsp_hs = (div_valid === 1'b1) && div_ready;
      if (rsp_hs) begin
        rsp_a = div_dividend; rsp_b = div_divisor; rsp_s = div_signed;
      end
      @(posedge div_clk); #1;
      div_complete = 1'b0;
      if (div_reset) begin
        rsp_busy = 1'b0; div_ready = 1'b1;
      end else if (rsp_hs) begin
        rsp_busy = 1'b1; rsp_cnt = lat; div_ready = 1'b0;
      end else if (rsp_busy) begin
        if (rsp_cnt <= 1) begin
          if (rsp_b == 32'd0) begin
            div_quo = 32'hFFFF_FFFF; div_rem = rsp_a;
          end else if (rsp_s) begin
            div_quo = 32'($signed(rsp_a) / $signed(rsp_b));
            div_rem = 32'($signed(rsp_a) % $signed(rsp_b));
          end else begin
            div_quo = rsp_a / rsp_b; div_rem = rsp_a % rsp_b;
          end
          div_complete = 1'b1; rsp_busy = 1'b0; div_ready = 1'b1;
        end else rsp_cnt--;
      end
    end
  end

  task automatic tick();
    @(posedge div_clk); #1;
  endtask

  task automatic drive(input logic v, input logic d, input logic s, input logic [31:0] rs,
                       input logic [31:0] rt, input logic mh, input logic ml,
                       input logic [31:0] md, input logic fl);
    ex_valid = v; ex_div = d; ex_div_signed = s; ex_rs = rs; ex_rt = rt;
    ex_mthi = mh; ex_mtlo = ml; ex_mt_data = md; ex_flush = fl;
  endtask

  // Counts consecutive stalled cycles, starting with the current one
  task automatic stall_len(output int n);
    bit done;
    n = 0; done = 1'b0;
    while (!done) begin
      @(negedge div_clk);
      if (!ex_stall) done = 1'b1;
      else begin
        n++;
        if (n > 200) begin
          check("stall_timeout", 32'd1, 32'd0);
          done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int hs0;
    div_reset = 1'b1;
    drive(0, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 0);
    tick(); tick();
    @(negedge div_clk);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_div_valid", 32'(div_valid), 32'd0);
    check("reset_ex_stall", 32'(ex_stall), 32'd0);
    tick();
    div_reset = 1'b0;
    mon_en = 1'b1;

    // DIVU 100/7
    lat = 4;
    req_q.push_back('{32'd100, 32'd7, 1'b0});
    hilo_q.push_back('{32'd2, 32'd14});
    drive(1, 1, 0, 32'd100, 32'd7, 0, 0, 32'd0, 0);
    stall_len(n);
    check("divu_stall_cycles", 32'(n), 32'd7);
    tick(); drive(0, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 0);
    tick();

    // DIV -7/2 signed
    lat = 1;
    req_q.push_back('{32'hFFFF_FFF9, 32'd2, 1'b1});
    hilo_q.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFD});
    drive(1, 1, 1, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'd0, 0);
    stall_len(n);
    check("div_signed_stall_cycles", 32'(n), 32'd4);
    tick(); drive(0, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 0);
    tick();

    // Flush 5 cycles into WAIT, then a new divide must wait out the drain
    lat = 12;
    req_q.push_back('{32'd50, 32'd5, 1'b1});
    drive(1, 1, 1, 32'd50, 32'd5, 0, 0, 32'd0, 0);
    repeat (7) tick();
    hs0 = hs_cnt;
    ex_flush = 1'b1;
    @(negedge div_clk);
    check("flush_wait_stall", 32'(ex_stall), 32'd0);
    tick();
    lat = 3;
    req_q.push_back('{32'd1000, 32'd10, 1'b0});
    hilo_q.push_back('{32'd0, 32'd100});
    drive(1, 1, 0, 32'd1000, 32'd10, 0, 0, 32'd0, 0);
    stall_len(n);
    check("drain_stall_cycles", 32'(n), 32'd13);
    check("drain_hi_kept", hi, 32'hFFFF_FFFF);
    check("drain_lo_kept", lo, 32'hFFFF_FFFD);
    check("drain_one_new_request", 32'(hs_cnt - hs0), 32'd1);
    tick(); drive(0, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 0);
    tick();

    // DIVU 9/4 then MTHI 0x55 right after
    lat = 2;
    req_q.push_back('{32'd9, 32'd4, 1'b0});
    hilo_q.push_back('{32'd1, 32'd2});
    hilo_q.push_back('{32'h55, 32'd2});
    drive(1, 1, 0, 32'd9, 32'd4, 0, 0, 32'd0, 0);
    stall_len(n);
    check("divu94_stall_cycles", 32'(n), 32'd5);
    tick();
    drive(1, 0, 0, 32'd0, 32'd0, 1, 0, 32'h55, 0);
    @(negedge div_clk);
    check("mthi_stall", 32'(ex_stall), 32'd0);
    tick(); drive(0, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 0);
    tick(); tick();

`ifdef DIV_ZERO_BYPASS_EN
    // Zero divisor resolved locally
    hs0 = hs_cnt;
    hilo_q.push_back('{32'h1234, 32'hFFFF_FFFF});
    drive(1, 1, 0, 32'h1234, 32'd0, 0, 0, 32'd0, 0);
    stall_len(n);
    check("bypass_stall_cycles", 32'(n), 32'd1);
    tick(); drive(0, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 0);
    tick(); tick();
    check("bypass_no_request", 32'(hs_cnt - hs0), 32'd0);
`endif

    // Reset while a divide is outstanding
    lat = 10;
    req_q.push_back('{32'd20, 32'd3, 1'b0});
    drive(1, 1, 0, 32'd20, 32'd3, 0, 0, 32'd0, 0);
    repeat (3) tick();
    hilo_q.push_back('{32'd0, 32'd0});
    div_reset = 1'b1;
    drive(0, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 0);
    tick();
    @(negedge div_clk);
    check("midreset_div_valid", 32'(div_valid), 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    check("midreset_ex_stall", 32'(ex_stall), 32'd0);
    tick();
    div_reset = 1'b0;
    hs0 = hs_cnt;
    repeat (5) tick();
    check("postreset_no_request", 32'(hs_cnt - hs0), 32'd0);
    check("postreset_div_valid", 32'(div_valid), 32'd0);

    check("scoreboard_empty", 32'(req_q.size() + hilo_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
